// File: rtl/spi_frame_decoder.sv
// SPI frame decoder: command byte (ECHO/WRITE/READ + channel), then payload against per-channel register banks.
// Latency: one response (valid_out/tx_byte) exactly 1 cycle after each accepted data_valid.
// Backpressure: none; every data_valid inside a CS window is answered, overruns get all-ones and raise err.
module spi_frame_decoder #(
    parameter int DATA_WIDTH       = 8,
    parameter int MAX_BYTES_PER_CS = 4,
    parameter int NUM_CHANNELS     = 4,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int NW = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs_active,
    input  logic                  data_valid,
    input  logic [NW-1:0]         RX_Count,
    input  logic [DATA_WIDTH-1:0] rx_byte,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  valid_out,
    output logic                  frame_done,
    output logic                  err,
    output logic [CW-1:0]         active_ch
);

    // Bank geometry: one entry per payload byte slot.
    localparam int DEPTH = MAX_BYTES_PER_CS - 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [NW-1:0]         MAX_N    = NW'(MAX_BYTES_PER_CS);
    localparam logic [NW-1:0]         ONE_N    = NW'(1);
    localparam logic [NW-1:0]         ZERO_N   = '0;
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    localparam logic [1:0] OP_ECHO  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [NW-1:0]           cnt_q, cnt_d;
    logic [NW-1:0]           cnt_exp_q, cnt_exp_d;
    logic [1:0]              op_q, op_d;
    logic [CW-1:0]           ch_d;
    logic [DATA_WIDTH-1:0]   tx_d;
    logic                    vout_d;
    logic                    fdone_d;
    logic                    err_d;

    logic                    cmd_fire;
    logic                    pay_fire;
    logic                    drain_fire;
    logic [1:0]              cmd_op;
    logic [NW-1:0]           cnt_inc;
    logic [IW-1:0]           slot_idx;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   bank [NUM_CHANNELS][DEPTH];

    assign cmd_op   = rx_byte[DATA_WIDTH-1 -: 2];
    assign cnt_inc  = cnt_q + ONE_N;
    // Payload slot is counter-1; counter stays below cnt_exp while in PAYLOAD.
    assign slot_idx = IW'(cnt_q - ONE_N);

    // Next-state, counter and response computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cnt_exp_d  = cnt_exp_q;
        op_d       = op_q;
        ch_d       = active_ch;
        tx_d       = tx_byte;
        vout_d     = 1'b0;
        fdone_d    = 1'b0;
        err_d      = err;
        wr_en      = 1'b0;
        cmd_fire   = 1'b0;
        pay_fire   = 1'b0;
        drain_fire = 1'b0;

        // Decide which kind of byte (if any) is handled this cycle.
        case (state_q)
            S_IDLE: begin
                if (cs_active) begin
                    cnt_exp_d = RX_Count;
                    cnt_d     = ZERO_N;
                    err_d     = 1'b0;
                    if (RX_Count == ZERO_N || RX_Count > MAX_N) begin
                        err_d      = 1'b1;
                        state_d    = S_DRAIN;
                        drain_fire = data_valid;
                    end else begin
                        state_d  = S_CMD;
                        cmd_fire = data_valid;
                    end
                end
            end
            S_CMD: begin
                cmd_fire = data_valid;
                if (!cs_active && !data_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                pay_fire = data_valid;
                if (!cs_active && !data_valid) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (!cs_active) begin
                    state_d = S_IDLE;
                end else begin
                    drain_fire = data_valid;
                end
            end
        endcase

        // Command byte: ack with its own value, unless the opcode is reserved.
        if (cmd_fire) begin
            vout_d = 1'b1;
            cnt_d  = ONE_N;
            op_d   = cmd_op;
            ch_d   = rx_byte[CW-1:0];
            if (cmd_op == OP_RSVD) begin
                tx_d    = ALL_ONES;
                err_d   = 1'b1;
                state_d = cs_active ? S_DRAIN : S_IDLE;
            end else begin
                tx_d = rx_byte;
                if (cnt_exp_d == ONE_N) begin
                    fdone_d = 1'b1;
                    state_d = cs_active ? S_DRAIN : S_IDLE;
                end else if (cs_active) begin
                    state_d = S_PAYLOAD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
        end

        // Payload byte: the byte is handled first, then a CS drop is treated as an abort.
        if (pay_fire) begin
            vout_d = 1'b1;
            cnt_d  = cnt_inc;
            case (op_q)
                OP_READ:  tx_d = bank[active_ch][slot_idx];
                OP_WRITE: begin
                    tx_d  = rx_byte;
                    wr_en = 1'b1;
                end
                default:  tx_d = rx_byte;
            endcase
            if (cnt_inc == cnt_exp_q) begin
                fdone_d = 1'b1;
                state_d = cs_active ? S_DRAIN : S_IDLE;
            end else if (!cs_active) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end

        // Bytes beyond the frame (or in a rejected frame) are overruns.
        if (drain_fire) begin
            vout_d = 1'b1;
            tx_d   = ALL_ONES;
            err_d  = 1'b1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cnt_exp_q  <= '0;
            op_q       <= OP_ECHO;
            active_ch  <= '0;
            tx_byte    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cnt_exp_q  <= cnt_exp_d;
            op_q       <= op_d;
            active_ch  <= ch_d;
            tx_byte    <= tx_d;
            valid_out  <= vout_d;
            frame_done <= fdone_d;
            err        <= err_d;
        end
    end

    // Register banks: cleared on reset, written by WRITE payload bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    bank[c][e] <= '0;
                end
            end
        end else if (wr_en) begin
            bank[active_ch][slot_idx] <= rx_byte;
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder with hand-computed responses.
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the following edge.
// Each stimulus step is exactly one clock, so response latency is checked implicitly.
module tb_spi_frame_decoder;

    logic       clk;
    logic       rst;
    logic       cs_active;
    logic       data_valid;
    logic [2:0] RX_Count;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       valid_out;
    logic       frame_done;
    logic       err;
    logic [1:0] active_ch;

    int n_checks;
    int n_fail;

    spi_frame_decoder #(
        .DATA_WIDTH      (8),
        .MAX_BYTES_PER_CS(4),
        .NUM_CHANNELS    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_active (cs_active),
        .data_valid(data_valid),
        .RX_Count  (RX_Count),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .valid_out (valid_out),
        .frame_done(frame_done),
        .err       (err),
        .active_ch (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs, returning 1ns after the edge.
    task automatic step(input logic cs, input logic dv, input logic [7:0] b);
        cs_active  = cs;
        data_valid = dv;
        rx_byte    = b;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    // Send one byte with CS held high and check the response that follows.
    task automatic send(input string tag, input logic [7:0] b, input logic [7:0] exp_tx,
                        input logic exp_fd);
        step(1'b1, 1'b1, b);
        chk({tag, ".vld"}, 32'(valid_out), 32'd1);
        chk({tag, ".tx"}, 32'(tx_byte), 32'(exp_tx));
        chk({tag, ".fd"}, 32'(frame_done), 32'(exp_fd));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        cs_active  = 1'b0;
        data_valid = 1'b0;
        RX_Count   = 3'd0;
        rx_byte    = 8'h00;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("rst.tx",  32'(tx_byte),    32'h0);
        chk("rst.vld", 32'(valid_out),  32'h0);
        chk("rst.fd",  32'(frame_done), 32'h0);
        chk("rst.err", 32'(err),        32'h0);
        chk("rst.ch",  32'(active_ch),  32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);

        // WRITE ch1 = {0x11,0x22}
        RX_Count = 3'd3;
        step(1'b1, 1'b0, 8'h00);
        send("wr.b0", 8'h41, 8'h41, 1'b0);
        send("wr.b1", 8'h11, 8'h11, 1'b0);
        send("wr.b2", 8'h22, 8'h22, 1'b1);
        step(1'b0, 1'b0, 8'h00);
        chk("wr.vld_idle", 32'(valid_out), 32'h0);
        chk("wr.err", 32'(err), 32'h0);

        // READ ch1 returns what was written
        RX_Count = 3'd3;
        step(1'b1, 1'b0, 8'h00);
        send("rd.b0", 8'h81, 8'h81, 1'b0);
        send("rd.b1", 8'h00, 8'h11, 1'b0);
        send("rd.b2", 8'h00, 8'h22, 1'b1);
        chk("rd.ch", 32'(active_ch), 32'h1);
        chk("rd.err", 32'(err), 32'h0);
        step(1'b0, 1'b0, 8'h00);

        // ECHO back-to-back, first byte on the CS-rise cycle
        RX_Count = 3'd4;
        send("echo.b0", 8'h00, 8'h00, 1'b0);
        chk("echo.ch", 32'(active_ch), 32'h0);
        send("echo.b1", 8'hDE, 8'hDE, 1'b0);
        send("echo.b2", 8'hAD, 8'hAD, 1'b0);
        send("echo.b3", 8'hBE, 8'hBE, 1'b1);
        step(1'b1, 1'b0, 8'h00);
        chk("echo.vld_after", 32'(valid_out), 32'h0);
        chk("echo.err", 32'(err), 32'h0);
        step(1'b0, 1'b0, 8'h00);

        // Overrun
        RX_Count = 3'd2;
        step(1'b1, 1'b0, 8'h00);
        send("ovr.b0", 8'h02, 8'h02, 1'b0);
        send("ovr.b1", 8'h55, 8'h55, 1'b1);
        chk("ovr.err_before", 32'(err), 32'h0);
        send("ovr.b2", 8'h66, 8'hFF, 1'b0);
        chk("ovr.err", 32'(err), 32'h1);
        step(1'b0, 1'b0, 8'h00);
        chk("ovr.err_sticky", 32'(err), 32'h1);

        // Early abort of a WRITE to ch2
        RX_Count = 3'd4;
        step(1'b1, 1'b0, 8'h00);
        chk("abort.err_clr", 32'(err), 32'h0);
        send("abort.b0", 8'h42, 8'h42, 1'b0);
        send("abort.b1", 8'h99, 8'h99, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("abort.err", 32'(err), 32'h1);
        chk("abort.fd", 32'(frame_done), 32'h0);
        chk("abort.vld", 32'(valid_out), 32'h0);
        RX_Count = 3'd4;
        step(1'b1, 1'b0, 8'h00);
        send("abort.rd0", 8'h82, 8'h82, 1'b0);
        send("abort.rd1", 8'h00, 8'h99, 1'b0);
        send("abort.rd2", 8'h00, 8'h00, 1'b0);
        send("abort.rd3", 8'h00, 8'h00, 1'b1);
        chk("abort.rd_ch", 32'(active_ch), 32'h2);
        step(1'b0, 1'b0, 8'h00);

        // RX_Count out of range
        RX_Count = 3'd5;
        step(1'b1, 1'b0, 8'h00);
        chk("cnt5.err", 32'(err), 32'h1);
        send("cnt5.b0", 8'h41, 8'hFF, 1'b0);
        send("cnt5.b1", 8'h11, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 8'h00);

        // Reserved opcode
        RX_Count = 3'd3;
        step(1'b1, 1'b0, 8'h00);
        chk("rsvd.err_clr", 32'(err), 32'h0);
        send("rsvd.b0", 8'hC0, 8'hFF, 1'b0);
        chk("rsvd.err", 32'(err), 32'h1);
        send("rsvd.b1", 8'h12, 8'hFF, 1'b0);
        step(1'b0, 1'b0, 8'h00);

        // A clean frame clears err
        RX_Count = 3'd2;
        step(1'b1, 1'b0, 8'h00);
        chk("clean.err_clr", 32'(err), 32'h0);
        send("clean.b0", 8'h01, 8'h01, 1'b0);
        send("clean.b1", 8'h77, 8'h77, 1'b1);
        chk("clean.err", 32'(err), 32'h0);
        step(1'b0, 1'b0, 8'h00);

        // data_valid with CS low is ignored
        step(1'b0, 1'b1, 8'h55);
        chk("cslow.vld", 32'(valid_out), 32'h0);
        chk("cslow.tx", 32'(tx_byte), 32'h77);

        // Reset in the middle of a WRITE to ch1 (ch1 currently holds 0x11,0x22)
        RX_Count = 3'd3;
        step(1'b1, 1'b0, 8'h00);
        send("mrst.b0", 8'h41, 8'h41, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 8'h33);
        chk("mrst.tx",  32'(tx_byte),    32'h0);
        chk("mrst.vld", 32'(valid_out),  32'h0);
        chk("mrst.fd",  32'(frame_done), 32'h0);
        chk("mrst.err", 32'(err),        32'h0);
        chk("mrst.ch",  32'(active_ch),  32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        RX_Count = 3'd3;
        step(1'b1, 1'b0, 8'h00);
        send("mrst.rd0", 8'h81, 8'h81, 1'b0);
        send("mrst.rd1", 8'h00, 8'h00, 1'b0);
        send("mrst.rd2", 8'h00, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_decoder.md
Name: spi_frame_decoder

Overview:
Parametrised successor to the single-channel SPI byte decoder. Frames SPI traffic per chip-select window. Decodes the first byte of each frame as a command: ECHO, WRITE or READ, plus a channel index. Handles the remaining payload bytes against a per-channel register bank. Produces one response byte per received byte for the SPI slave to shift back to the master.

Parameters:
DATA_WIDTH, 8, width of rx_byte, tx_byte and bank entries; minimum 4.
MAX_BYTES_PER_CS, 4, maximum bytes per CS frame, command byte included; minimum 2.
NUM_CHANNELS, 4, number of register banks; power of 2, at most 2^(DATA_WIDTH-2).
Derived (local): CW = max(1, clog2(NUM_CHANNELS)); NW = clog2(MAX_BYTES_PER_CS+1); each bank holds MAX_BYTES_PER_CS-1 entries.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
cs_active  in  1  high while SPI chip select is asserted (already synchronised).
data_valid  in  1  one-cycle pulse; rx_byte is valid this cycle.
RX_Count  in  NW  expected bytes in the frame; sampled on the first cycle cs_active is high.
rx_byte  in  DATA_WIDTH  byte received from the SPI slave.
tx_byte  out  DATA_WIDTH  response byte; held until the next response.
valid_out  out  1  one-cycle pulse; tx_byte is valid.
frame_done  out  1  one-cycle pulse; frame completed with the expected count.
err  out  1  sticky error flag; cleared at the next frame start.
active_ch  out  CW  channel decoded for the current or last frame.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; tx_byte=0, valid_out=0, frame_done=0, err=0, active_ch=0, byte counter=0. All bank entries are cleared to 0. Reset mid-frame aborts the frame with no further responses.
- Command byte fields: bits [DATA_WIDTH-1:DATA_WIDTH-2] are the opcode (00 ECHO, 01 WRITE, 10 READ, 11 reserved). Bits [CW-1:0] are the channel; the remaining bits are ignored.
- Latency: every accepted data_valid produces valid_out exactly 1 cycle later, with tx_byte updated on the same edge. Back-to-back data_valid pulses are supported.
- IDLE state:
  - On cs_active=1, latch RX_Count into cnt_exp, clear the counter and clear err.
  - If cnt_exp is 0 or cnt_exp > MAX_BYTES_PER_CS, go to DRAIN and set err. Otherwise go to CMD.
  - A data_valid in the same cycle as the cs_active rise is treated as the command byte.
- CMD state:
  - On data_valid, decode the command and respond with tx_byte = rx_byte (command echo as ack). Counter becomes 1.
  - If the opcode is reserved, set err, respond all-ones and go to DRAIN.
  - If cnt_exp == 1, pulse frame_done and go to DRAIN. Otherwise go to PAYLOAD.
- PAYLOAD state: payload byte index i = counter-1, from 0 to cnt_exp-2.
  - ECHO: tx_byte = rx_byte.
  - WRITE: bank[ch][i] <= rx_byte; tx_byte = rx_byte.
  - READ: tx_byte = bank[ch][i]; rx_byte is ignored. A READ of an entry written in the same frame returns the new value.
  - The counter increments per byte. When the counter reaches cnt_exp, pulse frame_done together with the last valid_out, then go to DRAIN.
- DRAIN state:
  - Any data_valid gets response all-ones and sets err (overrun).
  - Go to IDLE on cs_active=0.
- Early CS deassert: if cs_active=0 in CMD or PAYLOAD before the count completes, set err, give no frame_done and go to IDLE. WRITE bytes already accepted stay committed.
- A data_valid while cs_active=0 is ignored: no response and no state change.
- If cs_active falls in the same cycle as a data_valid, that byte is still processed before the abort is evaluated.
- active_ch updates at command decode and holds until the next command.
- Counter width is NW. It never exceeds cnt_exp, so there is no wrap-around.

Test Plan:
- WRITE then READ: frame 1 = 0x41,0x11,0x22 with RX_Count=3, cs high, then low. Expect responses 0x41,0x11,0x22 and frame_done on byte 3. Frame 2 = 0x81,0x00,0x00 with RX_Count=3. Expect responses 0x81,0x11,0x22, active_ch=1, err=0.
- ECHO back-to-back: data_valid on 4 consecutive cycles with 0x00,0xDE,0xAD,0xBE and RX_Count=4. Expect valid_out on 4 consecutive cycles, each 1 cycle after its input, tx_byte equal to the inputs, frame_done with the 4th.
- Overrun: RX_Count=2, then 3 bytes 0x02,0x55,0x66. Expect responses 0x02,0x55,0xFF; frame_done on byte 2; err=1 after byte 3.
- Early abort: WRITE ch2 with RX_Count=4, send 0x42,0x99, then drop cs. Expect err=1 and no frame_done. A READ of ch2 returns 0x99,0x00,0x00.
- Bad frames:
  - RX_Count=5: err=1 at frame start; all bytes get 0xFF.
  - Opcode 11 (0xC0): response 0xC0 is replaced by 0xFF and err=1.
  - A following valid frame clears err.
- Reset mid-frame: assert rst after the command byte of a WRITE frame. Expect all outputs 0 the next cycle and banks cleared (READ returns 0x00).
